// File: rtl/cache_line.sv
// One cache line (valid, dirty, tag, data block) with its tag comparator and the
// 4-way LRU age tracker for the set. The dirty output is named dout because do is a reserved word.

module tag_eq #(
    parameter int unsigned W = 19
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    // Purely combinational bitwise equality over the full width.
    assign eq = (a == b);

endmodule

module cache_line #(
    parameter int unsigned TAG_W = 19,
    parameter int unsigned BLK_W = 512
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             v,
    input  logic             d,
    input  logic [TAG_W-1:0] tag,
    input  logic [BLK_W-1:0] blk,
    output logic             vo,
    output logic             dout,
    output logic [TAG_W-1:0] tago,
    output logic [BLK_W-1:0] blko,
    input  logic [TAG_W-1:0] cmp_tag,
    output logic             match,
    output logic             hit,
    input  logic [1:0]       updated,
    output logic [1:0]       oldest
);

    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned AGE_W    = 2;

    // Reset ordering: way 0 oldest (age 3), way 3 most recent (age 0).
    localparam logic [NUM_WAYS-1:0][AGE_W-1:0] AGE_RST = {2'd0, 2'd1, 2'd2, 2'd3};

    logic [NUM_WAYS-1:0][AGE_W-1:0] age_q;
    logic [NUM_WAYS-1:0][AGE_W-1:0] age_nxt;
    logic [AGE_W-1:0]               u_age;
    logic [1:0]                     oldest_nxt;

    tag_eq #(
        .W (TAG_W)
    ) u_tag_eq (
        .a  (tago),
        .b  (cmp_tag),
        .eq (match)
    );

    assign hit = match & vo;

    // Ages younger than the accessed way shift up by one; the accessed way becomes MRU.
    // Re-touching the MRU way leaves everything as is since nothing is younger than 0.
    always_comb begin
        age_nxt = age_q;
        u_age   = age_q[updated];
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (updated == 2'(i)) begin
                age_nxt[i] = '0;
            end else if (age_q[i] < u_age) begin
                age_nxt[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    // Exactly one way carries age 3 while ages stay a permutation.
    always_comb begin
        oldest_nxt = 2'd0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (age_nxt[i] == AGE_W'(3)) begin
                oldest_nxt = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            vo     <= 1'b0;
            dout   <= 1'b0;
            tago   <= '0;
            blko   <= '0;
            age_q  <= AGE_RST;
            oldest <= 2'd0;
        end else begin
            vo     <= v;
            dout   <= d;
            tago   <= tag;
            blko   <= blk;
            age_q  <= age_nxt;
            oldest <= oldest_nxt;
        end
    end

endmodule

// File: tb/tb_cache_line.sv
// Bench for cache_line: a vector table plus hand-written sequences, checked through a scoreboard
// queue against a recency-list LRU model.

module tb_cache_line;

    localparam int unsigned TAG_W = 19;
    localparam int unsigned BLK_W = 512;

    logic             clk = 1'b0;
    logic             rst_b, v, d;
    logic [TAG_W-1:0] tag, tago, cmp_tag;
    logic [BLK_W-1:0] blk, blko;
    logic             vo, dout, match, hit;
    logic [1:0]       updated, oldest;

    cache_line #(.TAG_W(TAG_W), .BLK_W(BLK_W)) dut (
        .clk(clk), .rst_b(rst_b), .v(v), .d(d), .tag(tag), .blk(blk),
        .vo(vo), .dout(dout), .tago(tago), .blko(blko), .cmp_tag(cmp_tag),
        .match(match), .hit(hit), .updated(updated), .oldest(oldest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst_b;
        logic             v;
        logic             d;
        logic [TAG_W-1:0] tag;
        logic [BLK_W-1:0] blk;
        logic [1:0]       upd;
        logic [TAG_W-1:0] cmp;
    } stim_t;

    typedef struct {
        logic             vo;
        logic             dq;
        logic [TAG_W-1:0] tago;
        logic [BLK_W-1:0] blko;
        logic             match;
        logic             hit;
        logic [1:0]       oldest;
        string            name;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    exp_t sb[$];
    int   rec[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Recency list, most recent first; the last entry is the LRU way.
    function automatic void lru_reset();
        rec = {3, 2, 1, 0};
    endfunction

    function automatic void lru_touch(input int u);
        for (int i = 0; i < rec.size(); i++) begin
            if (rec[i] == u) begin
                rec.delete(i);
                break;
            end
        end
        rec.push_front(u);
    endfunction

    function automatic stim_t mk_stim(input logic r, input logic vv, input logic dd,
                                      input logic [TAG_W-1:0] t, input logic [BLK_W-1:0] b,
                                      input logic [1:0] u, input logic [TAG_W-1:0] c);
        stim_t s;
        s.rst_b = r; s.v = vv; s.d = dd; s.tag = t; s.blk = b; s.upd = u; s.cmp = c;
        return s;
    endfunction

    function automatic exp_t mk_exp(input string nm, input logic vv, input logic dd,
                                    input logic [TAG_W-1:0] t, input logic [BLK_W-1:0] b,
                                    input logic [TAG_W-1:0] c);
        exp_t e;
        e.name = nm; e.vo = vv; e.dq = dd; e.tago = t; e.blko = b;
        e.match = (t == c); e.hit = (t == c) && vv; e.oldest = 2'd0;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".vo"},     BLK_W'(vo),     BLK_W'(e.vo));
        chk({e.name, ".do"},     BLK_W'(dout),   BLK_W'(e.dq));
        chk({e.name, ".tago"},   BLK_W'(tago),   BLK_W'(e.tago));
        chk({e.name, ".blko"},   blko,           e.blko);
        chk({e.name, ".match"},  BLK_W'(match),  BLK_W'(e.match));
        chk({e.name, ".hit"},    BLK_W'(hit),    BLK_W'(e.hit));
        chk({e.name, ".oldest"}, BLK_W'(oldest), BLK_W'(e.oldest));
    endtask

    // Drive one edge; old_x >= 0 forces the expected oldest, otherwise the model supplies it.
    task automatic run(input stim_t s, input exp_t e, input int old_x);
        @(negedge clk);
        rst_b = s.rst_b; v = s.v; d = s.d; tag = s.tag; blk = s.blk;
        updated = s.upd; cmp_tag = s.cmp;
        if (!s.rst_b) lru_reset();
        else lru_touch(int'(s.upd));
        e.oldest = (old_x >= 0) ? 2'(old_x) : 2'(rec[3]);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset(input string nm);
        run(mk_stim(1'b0, 1'b1, 1'b1, '1, '1, 2'd3, '0), mk_exp(nm, 1'b0, 1'b0, '0, '0, '0), 0);
    endtask

    task automatic idle(input string nm, input logic [1:0] u, input int old_x);
        run(mk_stim(1'b1, 1'b0, 1'b0, '0, '0, u, '0), mk_exp(nm, 1'b0, 1'b0, '0, '0, '0), old_x);
    endtask

    vec_t vec[6];

    initial begin
        logic [TAG_W-1:0] t0, tr, cr;
        logic [BLK_W-1:0] b0, br;
        stim_t s;
        logic [TAG_W-1:0] one;

        rst_b = 1'b0; v = 1'b0; d = 1'b0; tag = '0; blk = '0; updated = 2'd0; cmp_tag = '0;
        lru_reset();
        t0 = 19'h12345;
        b0 = 512'd1234;

        vec[0] = '{s: mk_stim(1'b0, 1'b1, 1'b1, '1, '1, 2'd2, '0),
                   e: '{vo: 1'b0, dq: 1'b0, tago: '0, blko: '0, match: 1'b1, hit: 1'b0, oldest: 2'd0, name: "rst"}};
        vec[1] = '{s: mk_stim(1'b1, 1'b1, 1'b0, t0, b0, 2'd0, t0),
                   e: '{vo: 1'b1, dq: 1'b0, tago: t0, blko: b0, match: 1'b1, hit: 1'b1, oldest: 2'd0, name: "load_hit"}};
        vec[2] = '{s: mk_stim(1'b1, 1'b1, 1'b0, t0, b0, 2'd1, 19'h12344),
                   e: '{vo: 1'b1, dq: 1'b0, tago: t0, blko: b0, match: 1'b0, hit: 1'b0, oldest: 2'd0, name: "miss"}};
        vec[3] = '{s: mk_stim(1'b1, 1'b0, 1'b1, t0, '1, 2'd3, t0),
                   e: '{vo: 1'b0, dq: 1'b1, tago: t0, blko: '1, match: 1'b1, hit: 1'b0, oldest: 2'd0, name: "invalid"}};
        vec[4] = '{s: mk_stim(1'b0, 1'b1, 1'b1, 19'h7ffff, '1, 2'd1, 19'h7ffff),
                   e: '{vo: 1'b0, dq: 1'b0, tago: '0, blko: '0, match: 1'b0, hit: 1'b0, oldest: 2'd0, name: "rst_mid"}};
        vec[5] = '{s: mk_stim(1'b1, 1'b1, 1'b1, 19'h7ffff, '1, 2'd0, 19'h7ffff),
                   e: '{vo: 1'b1, dq: 1'b1, tago: 19'h7ffff, blko: '1, match: 1'b1, hit: 1'b1, oldest: 2'd0, name: "all_ones"}};

        for (int i = 0; i < 6; i++) run(vec[i].s, vec[i].e, -1);

        // Load, hold by feedback for five edges, then reset.
        do_reset("h_rst");
        run(mk_stim(1'b1, 1'b1, 1'b0, t0, b0, 2'd0, t0), mk_exp("h_load", 1'b1, 1'b0, t0, b0, t0), 1);
        for (int i = 0; i < 5; i++) begin
            s = mk_stim(1'b1, vo, dout, tago, blko, 2'd0, t0);
            run(s, mk_exp($sformatf("hold%0d", i), 1'b1, 1'b0, t0, b0, t0), 1);
        end
        do_reset("h_rst2");

        // LRU rotation through all ways.
        idle("rot0", 2'd0, 1);
        idle("rot1", 2'd1, 2);
        idle("rot2", 2'd2, 3);
        idle("rot3", 2'd3, 0);

        // Repeated access to one way.
        do_reset("r_rst");
        for (int i = 0; i < 4; i++) idle($sformatf("rep%0d", i), 2'd2, 0);

        // Reverse order then re-touch way 3.
        do_reset("v_rst");
        idle("rev3", 2'd3, -1);
        idle("rev2", 2'd2, -1);
        idle("rev1", 2'd1, -1);
        idle("rev0", 2'd0, 3);
        idle("rev3b", 2'd3, 2);

        // Single-bit comparator sweep against a held tag.
        do_reset("c_rst");
        run(mk_stim(1'b1, 1'b1, 1'b0, t0, b0, 2'd0, t0), mk_exp("c_eq", 1'b1, 1'b0, t0, b0, t0), -1);
        for (int i = 0; i < int'(TAG_W); i++) begin
            one = TAG_W'(1) << i;
            run(mk_stim(1'b1, 1'b1, 1'b0, t0, b0, 2'(i), t0 ^ one),
                mk_exp($sformatf("c_bit%0d", i), 1'b1, 1'b0, t0, b0, t0 ^ one), -1);
        end

        // Random loads and accesses.
        for (int i = 0; i < 40; i++) begin
            tr = TAG_W'($urandom);
            cr = ($urandom_range(0, 1) == 0) ? tr : TAG_W'($urandom);
            for (int k = 0; k < int'(BLK_W / 32); k++) br[k*32 +: 32] = $urandom;
            s = mk_stim(1'b1, 1'($urandom), 1'($urandom), tr, br, 2'($urandom), cr);
            if ($urandom_range(0, 15) == 0) begin
                s.rst_b = 1'b0;
                run(s, mk_exp($sformatf("rnd%0d", i), 1'b0, 1'b0, '0, '0, cr), -1);
            end else begin
                run(s, mk_exp($sformatf("rnd%0d", i), s.v, s.d, tr, br, cr), -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_line.md
CACHE_LINE -- requirements
Module: cache_line

Interface
REQ-001 Parameter TAG_W, default 19, tag width in bits.
REQ-002 Parameter BLK_W, default 512, data block width in bits (64 bytes).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 v  input  1  next valid bit.
REQ-006 d  input  1  next dirty bit.
REQ-007 tag  input  TAG_W  next tag.
REQ-008 blk  input  BLK_W  next data block.
REQ-009 vo  output  1  stored valid bit.
REQ-010 do  output  1  stored dirty bit.
REQ-011 tago  output  TAG_W  stored tag.
REQ-012 blko  output  BLK_W  stored block.
REQ-013 cmp_tag  input  TAG_W  tag under lookup.
REQ-014 match  output  1  stored tag equals cmp_tag, combinational.
REQ-015 hit  output  1  match AND vo, combinational.
REQ-016 updated  input  2  way index (0-3) accessed this cycle, for the set's LRU tracker.
REQ-017 oldest  output  2  least-recently-used way index of the set, registered.

Function
REQ-018 Line storage: each rising edge with rst_b=1 SHALL load v, d, tag and blk unconditionally into vo, do, tago and blko; the parent holds a value by feeding the outputs back.
REQ-019 vo, do, tago and blko SHALL be pure register outputs; no combinational path from v/d/tag/blk.
REQ-020 Comparator: a parameterized equality submodule SHALL compute match = (tago == cmp_tag), bitwise over all TAG_W bits, with no clock dependency.
REQ-021 hit SHALL be 0 whenever vo=0, regardless of tag equality.
REQ-022 LRU tracker SHALL keep four 2-bit ages age[0..3] forming a permutation of {0,1,2,3}, where 0 = most recent and 3 = oldest.
REQ-023 Every rising edge with rst_b=1 counts as an access to way u=updated: ages less than age[u] SHALL increment by 1, age[u] SHALL become 0, and all other ages SHALL remain unchanged.
REQ-024 Re-accessing the current MRU way (age[u]=0) SHALL leave all ages unchanged.
REQ-025 oldest SHALL be the index of the way whose age is 3, derived from registered ages (it reflects the state after the last edge).
REQ-026 The ages SHALL always remain a permutation; no illegal state reachable after reset.

Reset
REQ-027 On a rising edge with rst_b=0: vo=0, do=0, tago=0, blko=0, age[i]=3-i (so oldest=0); reset dominates all inputs.
REQ-028 Reset asserted mid-operation SHALL discard that cycle's inputs; normal loading resumes on the first edge with rst_b=1.
REQ-029 With stored values at reset (tago=0, vo=0), cmp_tag=0 SHALL give match=1 and hit=0.

Verification
REQ-030 Reset, then v=1, d=0, tag=19'h12345, blk=512'd1234 for one edge -> vo=1, do=0, tago=19'h12345, blko=1234; cmp_tag=19'h12345 -> match=1, hit=1; cmp_tag=19'h12344 -> match=0, hit=0.
REQ-031 Hold by feeding outputs back for 5 edges -> outputs unchanged; then rst_b=0 for one edge -> all outputs 0 and oldest=0.
REQ-032 After reset, updated=0 -> oldest=1; then updated=1 -> oldest=2; then updated=2 -> oldest=3; then updated=3 -> oldest=0.
REQ-033 After reset, updated=2 applied for 4 consecutive edges -> oldest=0 after every edge, and the ages do not change after the first edge.
REQ-034 After reset, sequence updated=3,2,1,0 -> oldest=3; then updated=3 -> oldest=2.
REQ-035 Comparator sweep: cmp_tag differing from tago in each single bit position (0..TAG_W-1) -> match=0; identical -> match=1.
